// File: rtl/traffic_conflict_monitor_if.sv
// Controller-to-lamp bus seen by the traffic conflict monitor.
// The master drives controller patterns; the slave returns lamps and fault status.
interface traffic_conflict_monitor_if;
  logic [2:0] i_ctl_w_to_e;
  logic [2:0] i_ctl_w_to_n;
  logic [2:0] i_ctl_e_to_w;
  logic [2:0] i_ctl_e_to_n;
  logic [2:0] i_ctl_n_to_e;
  logic [2:0] i_ctl_n_to_w;
  logic       i_clear_fault;
  logic [2:0] o_lamp_w_to_e;
  logic [2:0] o_lamp_w_to_n;
  logic [2:0] o_lamp_e_to_w;
  logic [2:0] o_lamp_e_to_n;
  logic [2:0] o_lamp_n_to_e;
  logic [2:0] o_lamp_n_to_w;
  logic       o_fault;
  logic [2:0] o_fault_code;
  logic [2:0] o_fault_chan;

  modport master (
    output i_ctl_w_to_e, i_ctl_w_to_n, i_ctl_e_to_w,
    output i_ctl_e_to_n, i_ctl_n_to_e, i_ctl_n_to_w,
    output i_clear_fault,
    input  o_lamp_w_to_e, o_lamp_w_to_n, o_lamp_e_to_w,
    input  o_lamp_e_to_n, o_lamp_n_to_e, o_lamp_n_to_w,
    input  o_fault, o_fault_code, o_fault_chan
  );

  modport slave (
    input  i_ctl_w_to_e, i_ctl_w_to_n, i_ctl_e_to_w,
    input  i_ctl_e_to_n, i_ctl_n_to_e, i_ctl_n_to_w,
    input  i_clear_fault,
    output o_lamp_w_to_e, o_lamp_w_to_n, o_lamp_e_to_w,
    output o_lamp_e_to_n, o_lamp_n_to_e, o_lamp_n_to_w,
    output o_fault, o_fault_code, o_fault_chan
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between traffic_controller and lamp drivers: registers the six
// movement patterns and forces all-red with a latched fault on unsafe behaviour.
module traffic_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int MAX_GO     = 200,
  parameter int RED_CLEAR  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_conflict_monitor_if.slave  bus
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] YEL_MIN = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] GO_MAX  = CNT_W'(MAX_GO);
  localparam logic [CNT_W-1:0] CLR_N   = CNT_W'(RED_CLEAR);

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    FAULT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] f_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [2:0] f_low(input logic [5:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic f_ok(input logic [2:0] p);
    return (p == RED) || (p == YEL) || (p == GRN);
  endfunction

  logic [2:0]       w_ctl  [6];
  logic [2:0]       r_prev [6];
  logic [CNT_W-1:0] r_yel  [6];
  logic [CNT_W-1:0] r_go   [6];
  logic [2:0]       r_lamp [6];
  logic [2:0]       w_lamp [6];

  state_t           r_state;
  state_t           w_state;
  logic             r_fault;
  logic             w_fault;
  logic [2:0]       r_code;
  logic [2:0]       w_code;
  logic [2:0]       r_chan;
  logic [2:0]       w_chan;
  logic [CNT_W-1:0] r_clr;
  logic [CNT_W-1:0] w_clr;
  logic [CNT_W-1:0] w_clr_inc;

  logic [5:0] w_nred;
  logic [5:0] w_inv;
  logic [5:0] w_conf;
  logic [5:0] w_ill;
  logic [5:0] w_shy;
  logic [5:0] w_wd;
  logic [2:0] w_det_code;
  logic [2:0] w_det_chan;

  assign w_ctl[0] = bus.i_ctl_w_to_e;
  assign w_ctl[1] = bus.i_ctl_w_to_n;
  assign w_ctl[2] = bus.i_ctl_e_to_w;
  assign w_ctl[3] = bus.i_ctl_e_to_n;
  assign w_ctl[4] = bus.i_ctl_n_to_e;
  assign w_ctl[5] = bus.i_ctl_n_to_w;

  assign bus.o_lamp_w_to_e = r_lamp[0];
  assign bus.o_lamp_w_to_n = r_lamp[1];
  assign bus.o_lamp_e_to_w = r_lamp[2];
  assign bus.o_lamp_e_to_n = r_lamp[3];
  assign bus.o_lamp_n_to_e = r_lamp[4];
  assign bus.o_lamp_n_to_w = r_lamp[5];
  assign bus.o_fault       = r_fault;
  assign bus.o_fault_code  = r_code;
  assign bus.o_fault_chan  = r_chan;

  always_comb begin
    w_nred = '0;
    w_inv  = '0;
    w_ill  = '0;
    w_shy  = '0;
    w_wd   = '0;
    for (int i = 0; i < 6; i++) begin
      w_nred[i] = (w_ctl[i] != RED);
      w_inv[i]  = !f_ok(w_ctl[i]);
      w_ill[i]  = f_ok(r_prev[i]) && f_ok(w_ctl[i]) &&
                  (((r_prev[i] == RED) && (w_ctl[i] == YEL)) ||
                   ((r_prev[i] == GRN) && (w_ctl[i] == RED)) ||
                   ((r_prev[i] == YEL) && (w_ctl[i] == GRN)));
      w_shy[i]  = (r_prev[i] == YEL) && (w_ctl[i] == RED) &&
                  (r_yel[i] < YEL_MIN);
      w_wd[i]   = w_nred[i] && (r_go[i] == GO_MAX);
    end
  end

  // Each pair is flagged on its lower index so f_low yields the reported chan.
  always_comb begin
    w_conf    = '0;
    w_conf[0] = w_nred[0] && (w_nred[4] || w_nred[5]);
    w_conf[1] = w_nred[1] && (w_nred[2] || w_nred[4] || w_nred[5]);
    w_conf[2] = w_nred[2] && w_nred[5];
  end

  always_comb begin
    w_det_code = 3'd0;
    w_det_chan = 3'd0;
    if (|w_inv) begin
      w_det_code = 3'd1;
      w_det_chan = f_low(w_inv);
    end else if (|w_conf) begin
      w_det_code = 3'd2;
      w_det_chan = f_low(w_conf);
    end else if (|w_ill) begin
      w_det_code = 3'd3;
      w_det_chan = f_low(w_ill);
    end else if (|w_shy) begin
      w_det_code = 3'd4;
      w_det_chan = f_low(w_shy);
    end else if (|w_wd) begin
      w_det_code = 3'd5;
      w_det_chan = f_low(w_wd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        r_prev[i] <= RED;
        r_yel[i]  <= '0;
        r_go[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        r_prev[i] <= w_ctl[i];
        r_yel[i]  <= (w_ctl[i] == YEL) ? f_inc(r_yel[i]) : '0;
        r_go[i]   <= w_nred[i] ? f_inc(r_go[i]) : '0;
      end
    end
  end

  assign w_clr_inc = f_inc(r_clr);

  always_comb begin
    w_state = r_state;
    w_fault = r_fault;
    w_code  = r_code;
    w_chan  = r_chan;
    w_clr   = r_clr;
    for (int i = 0; i < 6; i++) w_lamp[i] = RED;
    unique case (r_state)
      MONITOR: begin
        if (w_det_code != 3'd0) begin
          w_state = FAULT;
          w_fault = 1'b1;
          w_code  = w_det_code;
          w_chan  = w_det_chan;
        end else begin
          for (int i = 0; i < 6; i++) w_lamp[i] = w_ctl[i];
        end
      end
      FAULT: begin
        if (bus.i_clear_fault) begin
          w_state = RECOVER;
          w_clr   = '0;
        end
      end
      RECOVER: begin
        if (|w_inv) begin
          w_state = FAULT;
          w_code  = 3'd1;
          w_chan  = f_low(w_inv);
          w_clr   = '0;
        end else if (w_nred == 6'd0) begin
          w_clr = w_clr_inc;
          if (w_clr_inc == CLR_N) begin
            w_state = MONITOR;
            w_fault = 1'b0;
            w_code  = 3'd0;
            w_chan  = 3'd0;
            w_clr   = '0;
          end
        end else begin
          w_clr = '0;
        end
      end
      default: begin
        w_state = MONITOR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MONITOR;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_chan  <= 3'd0;
      r_clr   <= '0;
      for (int i = 0; i < 6; i++) r_lamp[i] <= RED;
    end else begin
      r_state <= w_state;
      r_fault <= w_fault;
      r_code  <= w_code;
      r_chan  <= w_chan;
      r_clr   <= w_clr;
      for (int i = 0; i < 6; i++) r_lamp[i] <= w_lamp[i];
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Testbench for traffic_conflict_monitor: directed scenarios plus random
// traffic compared each cycle against a rule-level reference model.
module tb_traffic_conflict_monitor;

  localparam int MIN_YELLOW = 3;
  localparam int MAX_GO     = 8;
  localparam int RED_CLEAR  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [2:0] c    [6];
  logic [2:0] lamp [6];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_conflict_monitor_if bus ();

  traffic_conflict_monitor #(
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_GO     (MAX_GO),
    .RED_CLEAR  (RED_CLEAR),
    .CNT_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.i_ctl_w_to_e  = c[0];
  assign bus.i_ctl_w_to_n  = c[1];
  assign bus.i_ctl_e_to_w  = c[2];
  assign bus.i_ctl_e_to_n  = c[3];
  assign bus.i_ctl_n_to_e  = c[4];
  assign bus.i_ctl_n_to_w  = c[5];
  assign bus.i_clear_fault = clr;
  assign lamp[0] = bus.o_lamp_w_to_e;
  assign lamp[1] = bus.o_lamp_w_to_n;
  assign lamp[2] = bus.o_lamp_e_to_w;
  assign lamp[3] = bus.o_lamp_e_to_n;
  assign lamp[4] = bus.o_lamp_n_to_e;
  assign lamp[5] = bus.o_lamp_n_to_w;

  // Reference model: mode 0 monitor, 1 fault, 2 recover.
  int m_prev [6];
  int m_yel  [6];
  int m_go   [6];
  int m_lamp [6];
  int m_mode;
  int m_fault;
  int m_code;
  int m_chan;
  int m_clr;

  localparam logic [24:0] RST_VEC = {{6{3'b100}}, 1'b0, 3'd0, 3'd0};

  function automatic int phase(input int p);
    case (p)
      4:       return 0;
      1:       return 1;
      2:       return 2;
      default: return -1;
    endcase
  endfunction

  function automatic int next_lit(input int p);
    case (p)
      4:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic detect(output int code, output int chan);
    int pa [6];
    int pb [6];
    int best;
    pa = '{1, 1, 1, 0, 2, 0};
    pb = '{2, 4, 5, 5, 5, 4};
    code = 0;
    chan = 0;
    for (int i = 0; i < 6; i++)
      if (phase(int'(c[i])) < 0) begin code = 1; chan = i; return; end
    best = 9;
    for (int p = 0; p < 6; p++)
      if (c[pa[p]] != 3'b100 && c[pb[p]] != 3'b100 && pa[p] < best)
        best = pa[p];
    if (best < 9) begin code = 2; chan = best; return; end
    for (int i = 0; i < 6; i++) begin
      int a;
      int b;
      a = phase(m_prev[i]);
      b = phase(int'(c[i]));
      if (a >= 0 && b >= 0 && b != a && b != (a + 1) % 3) begin
        code = 3; chan = i; return;
      end
    end
    for (int i = 0; i < 6; i++)
      if (m_prev[i] == 2 && c[i] == 3'b100 && m_yel[i] < MIN_YELLOW) begin
        code = 4; chan = i; return;
      end
    for (int i = 0; i < 6; i++)
      if (c[i] != 3'b100 && m_go[i] == MAX_GO) begin
        code = 5; chan = i; return;
      end
  endtask

  task automatic model_edge();
    int code;
    int chan;
    bit any_inv;
    bit all_red;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_prev[i] = 4; m_yel[i] = 0; m_go[i] = 0; m_lamp[i] = 4;
      end
      m_mode = 0; m_fault = 0; m_code = 0; m_chan = 0; m_clr = 0;
      return;
    end
    detect(code, chan);
    any_inv = (code == 1);
    all_red = 1'b1;
    for (int i = 0; i < 6; i++) if (c[i] != 3'b100) all_red = 1'b0;
    for (int i = 0; i < 6; i++) m_lamp[i] = 4;
    if (m_mode == 0) begin
      if (code != 0) begin
        m_mode = 1; m_fault = 1; m_code = code; m_chan = chan;
      end else begin
        for (int i = 0; i < 6; i++) m_lamp[i] = int'(c[i]);
      end
    end else if (m_mode == 1) begin
      if (clr) begin m_mode = 2; m_clr = 0; end
    end else begin
      if (any_inv) begin
        m_mode = 1; m_code = 1; m_chan = chan; m_clr = 0;
      end else if (all_red) begin
        m_clr++;
        if (m_clr == RED_CLEAR) begin
          m_mode = 0; m_fault = 0; m_code = 0; m_chan = 0; m_clr = 0;
        end
      end else begin
        m_clr = 0;
      end
    end
    for (int i = 0; i < 6; i++) begin
      m_yel[i]  = (c[i] == 3'b010) ? m_yel[i] + 1 : 0;
      m_go[i]   = (c[i] != 3'b100) ? m_go[i] + 1 : 0;
      m_prev[i] = int'(c[i]);
    end
  endtask

  function automatic logic [24:0] obs();
    return {lamp[0], lamp[1], lamp[2], lamp[3], lamp[4], lamp[5],
            bus.o_fault, bus.o_fault_code, bus.o_fault_chan};
  endfunction

  function automatic logic [24:0] expv();
    return {3'(m_lamp[0]), 3'(m_lamp[1]), 3'(m_lamp[2]),
            3'(m_lamp[3]), 3'(m_lamp[4]), 3'(m_lamp[5]),
            1'(m_fault), 3'(m_code), 3'(m_chan)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic all_red();
    for (int i = 0; i < 6; i++) c[i] = 3'b100;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    all_red();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (obs() !== RST_VEC) begin
      bad++;
      $display("FAIL reset: got %h want %h", obs(), RST_VEC);
    end
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL reset_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_passthrough();
    int seq [6];
    seq = '{4, 1, 2, 2, 2, 4};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      c[0] = 3'(seq[k]);
      tick();
      total++;
      if (lamp[0] !== 3'(seq[k]) || bus.o_fault !== 1'b0) begin
        bad++;
        $display("FAIL pass_%0d: got lamp=%b fault=%b want lamp=%b fault=0",
                 k, lamp[0], bus.o_fault, 3'(seq[k]));
      end
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL pass_model_%0d: got %h want %h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_conflict();
    do_reset();
    c[1] = 3'b001;
    c[2] = 3'b001;
    tick();
    total++;
    if (obs() !== {{6{3'b100}}, 1'b1, 3'd2, 3'd1}) begin
      bad++;
      $display("FAIL conflict: got %h want code=2 chan=1 all red", obs());
    end
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL conflict_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_yellow();
    int seq [4];
    seq = '{1, 2, 2, 4};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      c[0] = 3'(seq[k]);
      tick();
    end
    total++;
    if ({bus.o_fault, bus.o_fault_code, bus.o_fault_chan} !== 7'b1_100_000) begin
      bad++;
      $display("FAIL short_yellow: got f=%b code=%0d chan=%0d want 1/4/0",
               bus.o_fault, bus.o_fault_code, bus.o_fault_chan);
    end
    do_reset();
    c[0] = 3'b001;
    tick();
    c[0] = 3'b100;
    tick();
    total++;
    if ({bus.o_fault, bus.o_fault_code, bus.o_fault_chan} !== 7'b1_011_000) begin
      bad++;
      $display("FAIL illegal_trans: got f=%b code=%0d chan=%0d want 1/3/0",
               bus.o_fault, bus.o_fault_code, bus.o_fault_chan);
    end
    total++;
    if (obs() !== expv()) begin
      bad++;
      $display("FAIL illegal_model: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_invalid();
    do_reset();
    c[5] = 3'b011;
    c[0] = 3'b111;
    tick();
    total++;
    if (obs() !== {{6{3'b100}}, 1'b1, 3'd1, 3'd0}) begin
      bad++;
      $display("FAIL invalid: got %h want code=1 chan=0 all red", obs());
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    c[3] = 3'b001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      total++;
      if (k < 9) begin
        if (lamp[3] !== 3'b001 || bus.o_fault !== 1'b0) begin
          bad++;
          $display("FAIL watchdog_go_%0d: got lamp=%b fault=%b want 001/0",
                   k, lamp[3], bus.o_fault);
        end
      end else begin
        if (obs() !== {{6{3'b100}}, 1'b1, 3'd5, 3'd3}) begin
          bad++;
          $display("FAIL watchdog: got %h want code=5 chan=3", obs());
        end
      end
    end
  endtask

  task automatic test_recover();
    do_reset();
    c[1] = 3'b001;
    c[2] = 3'b001;
    tick();
    all_red();
    c[4] = 3'b001;
    clr  = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clr = (k == 1);
      tick();
      total++;
      if (bus.o_fault !== 1'b1 || lamp[4] !== 3'b100) begin
        bad++;
        $display("FAIL recover_hold_%0d: got fault=%b lamp=%b want 1/100",
                 k, bus.o_fault, lamp[4]);
      end
    end
    clr = 1'b0;
    all_red();
    for (int k = 1; k <= RED_CLEAR; k++) begin
      tick();
      total++;
      if (bus.o_fault !== (k < RED_CLEAR) || obs() !== expv()) begin
        bad++;
        $display("FAIL recover_red_%0d: got %h want %h", k, obs(), expv());
      end
    end
    total++;
    if (obs() !== RST_VEC) begin
      bad++;
      $display("FAIL recover_exit: got %h want %h", obs(), RST_VEC);
    end
    c[0] = 3'b001;
    tick();
    total++;
    if (lamp[0] !== 3'b001 || bus.o_fault !== 1'b0) begin
      bad++;
      $display("FAIL resume: got lamp=%b fault=%b want 001/0",
               lamp[0], bus.o_fault);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    total++;
    if (lamp[0] !== 3'b001 || bus.o_fault !== 1'b0 ||
        bus.o_fault_code !== 3'd0) begin
      bad++;
      $display("FAIL clear_in_monitor: got lamp=%b fault=%b code=%0d want 001/0/0",
               lamp[0], bus.o_fault, bus.o_fault_code);
    end
  endtask

  task automatic test_reset_mid_fault();
    do_reset();
    c[2] = 3'b110;
    tick();
    total++;
    if (obs() !== {{6{3'b100}}, 1'b1, 3'd1, 3'd2}) begin
      bad++;
      $display("FAIL pre_reset_fault: got %h want code=1 chan=2", obs());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_red();
    total++;
    if (obs() !== RST_VEC) begin
      bad++;
      $display("FAIL reset_mid_fault: got %h want %h", obs(), RST_VEC);
    end
  endtask

  task automatic test_random();
    int burst;
    int errs;
    burst = 0;
    errs  = 0;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (burst > 0) begin
        all_red();
        burst--;
      end else if ($urandom_range(0, 99) < 6) begin
        all_red();
        burst = 5;
      end else begin
        for (int i = 0; i < 6; i++) begin
          int s;
          s = $urandom_range(0, 99);
          if (s >= 97) c[i] = 3'($urandom_range(0, 7));
          else if (s >= 70) c[i] = 3'(next_lit(int'(c[i])));
        end
      end
      clr = ($urandom_range(0, 9) == 0);
      tick();
      total++;
      if (obs() !== expv()) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_%0d: got %h want %h", n, obs(), expv());
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    all_red();
    test_reset();
    test_passthrough();
    test_conflict();
    test_yellow();
    test_invalid();
    test_watchdog();
    test_recover();
    test_reset_mid_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
